// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - multi-cycle accumulator CPU with internal RAM, Z/C flags, OUT handshake and halt control
// Optional single-step control: define CPU_SINGLE_STEP_EN.
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mbr,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] bus,
    output logic [2:0]        state,
    output logic              zf,
    output logic              cf,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH1 = 3'd1;
    localparam logic [2:0] S_FETCH2 = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int DEPTH = 2**ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we_c;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] bus_c;
    logic [DATA_W-1:0] pc_ext;
    logic [DATA_W-1:0] acc_not;
    logic [3:0]        opcode;
    logic              op_read;
    logic              step_go;

    logic [DATA_W:0]   add_w;
    logic [DATA_W:0]   sub_w;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cy;

`ifdef CPU_SINGLE_STEP_EN
    assign step_go = step;
`else
    logic unused_step;
    assign step_go     = 1'b0;
    assign unused_step = step;
`endif

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign op_read = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign rd_data = mem_q[mar_q];
    assign pc_ext  = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    assign acc_not = ~acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction boundaries fall back to IDLE when run is low, which also ends a single step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run || step_go) state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op_read)                 state_d = S_WB;
                else if (opcode == OP_HLT)   state_d = S_HALT;
                else                         state_d = run ? S_FETCH1 : S_IDLE;
            end
            S_WB:     state_d = run ? S_FETCH1 : S_IDLE;
            S_HALT:   if (!run) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        add_w   = {1'b0, acc_q} + {1'b0, mbr_q};
        sub_w   = {1'b0, acc_q} - {1'b0, mbr_q};
        alu_res = acc_q;
        alu_cy  = cf_q;
        case (opcode)
            OP_LDA: alu_res = mbr_q;
            OP_ADD: begin
                alu_res = add_w[DATA_W-1:0];
                alu_cy  = add_w[DATA_W];
            end
            OP_SUB: begin
                alu_res = sub_w[DATA_W-1:0];
                alu_cy  = sub_w[DATA_W];
            end
            OP_AND: alu_res = acc_q & mbr_q;
            OP_OR:  alu_res = acc_q | mbr_q;
            default: ;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        mbr_d       = mbr_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        zf_d        = zf_q;
        cf_d        = cf_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        bus_c       = '0;
        mem_we_c    = 1'b0;
        mem_waddr   = load_addr;
        mem_wdata   = load_data;
        case (state_q)
            S_IDLE, S_HALT: mem_we_c = load_we;
            S_FETCH1: begin
                mar_d = pc_q;
                bus_c = pc_ext;
            end
            S_FETCH2: begin
                mbr_d = rd_data;
                pc_d  = pc_q + ADDR_W'(1);
                bus_c = rd_data;
            end
            S_DECODE: begin
                ir_d  = mbr_q;
                mar_d = mbr_q[ADDR_W-1:0];
                bus_c = mbr_q;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        mbr_d = rd_data;
                        bus_c = rd_data;
                    end
                    OP_STA: begin
                        mem_we_c  = 1'b1;
                        mem_waddr = mar_q;
                        mem_wdata = acc_q;
                        mbr_d     = acc_q;
                        bus_c     = acc_q;
                    end
                    OP_JMP: pc_d = mar_q;
                    OP_JZ:  if (zf_q) pc_d = mar_q;
                    OP_JC:  if (cf_q) pc_d = mar_q;
                    OP_NOT: begin
                        acc_d = acc_not;
                        zf_d  = (acc_not == '0);
                    end
                    OP_OUT: begin
                        out_valid_d = 1'b1;
                        out_data_d  = acc_q;
                        bus_c       = acc_q;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                acc_d = alu_res;
                zf_d  = (alu_res == '0);
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) cf_d = alu_cy;
                bus_c = alu_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            mar_q       <= '0;
            mbr_q       <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            mbr_q       <= mbr_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            zf_q        <= zf_d;
            cf_q        <= cf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // RAM contents survive reset; writes are blocked while reset is held.
    assign mem_we = mem_we_c && reset;

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign pc        = pc_q;
    assign mar       = mar_q;
    assign mbr       = mbr_q;
    assign ir        = ir_q;
    assign acc       = acc_q;
    assign bus       = bus_c;
    assign state     = state_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb/tb_acc_cpu_core.sv - scoreboard bench for acc_cpu_core (DATA_W=8, ADDR_W=4)
module tb_acc_cpu_core;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH1 = 3'd1;
    localparam logic [2:0] S_FETCH2 = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       load_we = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic [3:0] pc, mar;
    logic [7:0] mbr, ir, acc, bus, out_data;
    logic [2:0] state;
    logic       zf, cf, out_valid, halted;

    int n_checks = 0;
    int n_errs   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] sb_exp;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .pc(pc), .mar(mar), .mbr(mbr), .ir(ir), .acc(acc), .bus(bus),
        .state(state), .zf(zf), .cf(cf), .out_valid(out_valid),
        .out_data(out_data), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_extra", {31'b0, out_valid}, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("out_data", {24'b0, out_data}, {24'b0, sb_exp});
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; step = 1'b0; load_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_addr = a; load_data = d; load_we = 1'b1;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state !== s) check(tag, {29'b0, state}, {29'b0, s});
    endtask

    task automatic wait_exec_ir(input logic [7:0] w, input int budget, input string tag);
        int n = 0;
        while (!(state === S_EXEC && ir === w) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(state === S_EXEC && ir === w)) check(tag, {24'b0, ir}, {24'b0, w});
    endtask

    task automatic run_to_halt(input string tag);
        run = 1'b1;
        wait_state(S_HALT, 300, tag);
        run = 1'b0;
        wait_state(S_IDLE, 5, "halt_exit");
    endtask

    task automatic load_prog1(input logic [7:0] m13);
        load(4'd0, 8'h1E); load(4'd1, 8'h3F); load(4'd2, 8'h2D);
        load(4'd3, 8'hB0); load(4'd4, 8'hF0);
        load(4'd13, m13); load(4'd14, 8'h05); load(4'd15, 8'h03);
    endtask

    task automatic sb_drain(input string tag);
        check(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset state
        do_reset();
        check("rst_pc", pc, 0);
        check("rst_acc", acc, 0);
        check("rst_state", state, S_IDLE);
        check("rst_halted", halted, 0);
        check("rst_bus", bus, 0);

        // Program 1: 5+3 stored to RAM13, OUT, HLT with exact latency
        load_prog1(8'h00);
        exp_q.push_back(8'h08);
        run = 1'b1;
        wait_state(S_FETCH1, 4, "p1_start");
        cyc = 0;
        while (state !== S_HALT && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("p1_cycles", cyc, 22);
        check("p1_halted", halted, 1);
        check("p1_pc", pc, 5);
        check("p1_acc", acc, 8'h08);
        run = 1'b0;
        wait_state(S_IDLE, 5, "p1_idle");
        sb_drain("p1_sb");

        // Read RAM13 back through a probe program
        do_reset();
        load(4'd0, 8'h1D); load(4'd1, 8'hB0); load(4'd2, 8'hF0);
        exp_q.push_back(8'h08);
        run_to_halt("probe13_halt");
        sb_drain("probe13_sb");

        // ADD overflow, taken JZ, SUB borrow
        do_reset();
        load(4'd0, 8'h1E); load(4'd1, 8'h3F); load(4'd2, 8'h99); load(4'd3, 8'hF0);
        load(4'd9, 8'hB0); load(4'd10, 8'h4F); load(4'd11, 8'hB0); load(4'd12, 8'hF0);
        load(4'd14, 8'hFF); load(4'd15, 8'h01);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        run = 1'b1;
        wait_exec_ir(8'h99, 50, "jz_reach");
        @(negedge clk);
        check("jz_pc", pc, 9);
        check("jz_acc", acc, 0);
        check("jz_zf", zf, 1);
        check("jz_cf", cf, 1);
        wait_state(S_HALT, 100, "p2_halt");
        check("sub_acc", acc, 8'hFF);
        check("sub_cf", cf, 1);
        check("sub_zf", zf, 0);
        check("p2_pc", pc, 13);
        run = 1'b0;
        wait_state(S_IDLE, 5, "p2_idle");
        sb_drain("p2_sb");

        // AND / OR / NOT, JC not taken with cf=0
        do_reset();
        load(4'd0, 8'h1E); load(4'd1, 8'h5F); load(4'd2, 8'hB0); load(4'd3, 8'h6F);
        load(4'd4, 8'hB0); load(4'd5, 8'h70); load(4'd6, 8'hB0); load(4'd7, 8'hAC);
        load(4'd8, 8'hF0); load(4'd12, 8'hF0);
        load(4'd14, 8'h0F); load(4'd15, 8'h3C);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        run_to_halt("logic_halt");
        check("logic_pc", pc, 9);
        check("logic_cf", cf, 0);
        check("logic_zf", zf, 0);
        sb_drain("logic_sb");

        // All-NOP memory: 4-cycle instructions, PC wraps
        do_reset();
        for (int a = 0; a < 16; a++) load(4'(a), 8'h00);
        run = 1'b1;
        wait_state(S_FETCH1, 4, "nop_start");
        for (int i = 1; i <= 17; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (state !== S_FETCH1 && cyc < 20);
            check($sformatf("nop_cycles%0d", i), cyc, 4);
            check($sformatf("nop_pc%0d", i), pc, i % 16);
        end
        run = 1'b0;
        wait_state(S_IDLE, 8, "nop_idle");
        sb_drain("nop_sb");

        // Reset during EXEC of STA aborts the write
        do_reset();
        load_prog1(8'h77);
        run = 1'b1;
        wait_exec_ir(8'h2D, 50, "sta_reach");
        reset = 1'b0;
        #1;
        check("ab_pc", pc, 0);
        check("ab_mar", mar, 0);
        check("ab_mbr", mbr, 0);
        check("ab_ir", ir, 0);
        check("ab_acc", acc, 0);
        check("ab_bus", bus, 0);
        check("ab_state", state, 0);
        check("ab_flags", {zf, cf}, 0);
        check("ab_out", {out_valid, out_data}, 0);
        check("ab_halted", halted, 0);
        @(negedge clk);
        run = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        load(4'd0, 8'h86); load(4'd6, 8'h1D); load(4'd7, 8'hB0); load(4'd8, 8'hF0);
        exp_q.push_back(8'h77);
        run_to_halt("ab_probe_halt");
        sb_drain("ab_probe_sb");
        do_reset();
        load(4'd0, 8'h1E);
        exp_q.push_back(8'h08);
        run_to_halt("ab_rerun_halt");
        check("ab_rerun_acc", acc, 8'h08);
        sb_drain("ab_rerun_sb");

        // load_we ignored in FETCH2, accepted in HALT
        do_reset();
        exp_q.push_back(8'h08);
        run = 1'b1;
        wait_state(S_FETCH2, 6, "ld_f2_reach");
        load_addr = 4'd3; load_data = 8'hF0; load_we = 1'b1;
        @(negedge clk);
        load_we = 1'b0;
        wait_state(S_HALT, 100, "ld_halt");
        check("ld_pc", pc, 5);
        load(4'd14, 8'h02);
        check("ld_hold_halt", state, S_HALT);
        run = 1'b0;
        wait_state(S_IDLE, 5, "ld_idle");
        sb_drain("ld_sb");
        do_reset();
        exp_q.push_back(8'h05);
        run_to_halt("reload_halt");
        sb_drain("reload_sb");

        // Single-step
        do_reset();
        load(4'd14, 8'h05);
`ifdef CPU_SINGLE_STEP_EN
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (8) @(negedge clk);
            check($sformatf("ss_state%0d", k), state, S_IDLE);
            check($sformatf("ss_pc%0d", k), pc, k);
            check($sformatf("ss_acc%0d", k), acc, (k == 1) ? 8'h05 : 8'h08);
        end
`else
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            check($sformatf("ss_off_state_a%0d", k), state, S_IDLE);
            repeat (8) @(negedge clk);
            check($sformatf("ss_off_state%0d", k), state, S_IDLE);
            check($sformatf("ss_off_pc%0d", k), pc, 0);
            check($sformatf("ss_off_acc%0d", k), acc, 0);
        end
`endif
        sb_drain("ss_sb");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU; next generation of the team's 8-bit/4-bit-address CPU.
- Generalised data and address widths, internal program/data RAM with a load port, Z/C flags, conditional jumps, an OUT handshake and halt/restart control.
- Top-level compute block; datapath registers (PC, MAR, MBR, IR, ACC, bus) exported for bench visibility.

Parameters:
- DATA_W, 8: data/instruction word width. Must satisfy DATA_W >= 4+ADDR_W.
- ADDR_W, 4: address width. RAM depth is 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  start/enable level.
- step  in  1  single-step pulse; used only with CPU_SINGLE_STEP_EN.
- load_we  in  1  RAM write strobe for program loading.
- load_addr  in  ADDR_W  RAM load address.
- load_data  in  DATA_W  RAM load data.
- pc  out  ADDR_W  program counter.
- mar  out  ADDR_W  memory address register.
- mbr  out  DATA_W  memory buffer register.
- ir  out  DATA_W  instruction register.
- acc  out  DATA_W  accumulator.
- bus  out  DATA_W  internal bus value (combinational).
- state  out  3  FSM state code.
- zf  out  1  zero flag.
- cf  out  1  carry/borrow flag.
- out_valid  out  1  one-cycle pulse on OUT.
- out_data  out  DATA_W  value latched by OUT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (reset=0):
  - All outputs and registers clear to 0; state=IDLE.
  - RAM is NOT cleared.
  - Reset asserted mid-instruction aborts it immediately; a pending STA write does not occur.
- Instruction format:
  - opcode = word[DATA_W-1:DATA_W-4].
  - operand = word[ADDR_W-1:0].
- Opcodes:
  - 0 NOP; 1 LDA; 2 STA; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 NOT; 8 JMP; 9 JZ; A JC; B OUT; F HLT.
  - C, D, E execute as NOP.
- State codes: IDLE=0, FETCH1=1, FETCH2=2, DECODE=3, EXEC=4, WB=5, HALT=6.
- IDLE:
  - run=1 → FETCH1 next cycle.
  - load_we writes RAM[load_addr]=load_data.
- FETCH1: MAR<=PC.
- FETCH2: MBR<=RAM[MAR]; PC<=PC+1, wrapping from 2**ADDR_W-1 to 0.
- DECODE: IR<=MBR; MAR<=MBR operand.
- EXEC, by opcode:
  - LDA/ADD/SUB/AND/OR: MBR<=RAM[MAR] → WB.
  - STA: RAM[MAR]<=ACC, MBR<=ACC.
  - JMP: PC<=MAR.
  - JZ: PC<=MAR if zf=1.
  - JC: PC<=MAR if cf=1.
  - NOT: ACC<=~ACC, zf updated.
  - OUT: out_data<=ACC, out_valid=1 for exactly this cycle.
  - HLT → HALT.
  - All other opcodes → FETCH1.
- WB:
  - ACC<=op(ACC,MBR) → FETCH1.
  - ADD: cf = carry out of bit DATA_W-1.
  - SUB: cf = borrow (ACC<MBR unsigned); result is ACC−MBR mod 2**DATA_W.
  - AND/OR: cf unchanged.
  - zf = (new ACC==0) for LDA/ADD/SUB/AND/OR/NOT.
  - cf changes only on ADD/SUB.
- Latency: memory-read ops take 5 cycles (FETCH1..WB); all others take 4 cycles.
- run deasserted mid-instruction: the instruction completes; FSM enters IDLE at the next FETCH1 boundary. PC is retained, so a later run resumes.
- HALT:
  - halted=1; load_we accepted.
  - Leaves to IDLE only after run=0 is sampled. PC/ACC/flags retained.
- load_we outside IDLE/HALT is ignored.
- bus, by state:
  - FETCH1: zero-extended PC.
  - FETCH2: RAM[MAR].
  - DECODE: MBR.
  - EXEC: RAM[MAR] for reads, ACC for STA/OUT, 0 otherwise.
  - WB: ALU result.
  - IDLE/HALT: 0.

Optional Feature:
- CPU_SINGLE_STEP_EN
- Defined: in IDLE with run=0, a one-cycle step=1 executes exactly one instruction (FETCH1 through its last state), then returns to IDLE. step is ignored outside IDLE. step and run together: run has priority.
- Undefined: step is ignored entirely; behaviour is identical to run=0.

Test Plan (DATA_W=8, ADDR_W=4):
- Load RAM0..4 = 1E,3F,2D,B0,F0 and RAM14=05, RAM15=03; run=1 → out_valid pulses once with out_data=08; RAM13=08; halted=1 exactly 22 cycles after FETCH1 entry; pc=5.
- ACC=FF (LDA), ADD of 01, then JZ to 9 → acc=00, zf=1, cf=1; pc=9 after the JZ EXEC. SUB 01 from 00 → acc=FF, cf=1, zf=0.
- All 16 RAM words = 00 (NOP), run=1 → pc sequences 1..F,0,1; each instruction takes 4 cycles; no out_valid.
- reset driven low in EXEC of STA → all outputs 0 immediately; target RAM word unchanged; RAM program intact, so rerunning reproduces the first result.
- load_we during FETCH2 with load_addr=3 → RAM3 unchanged. In HALT, run=0 → IDLE; reload and rerun works.
- With CPU_SINGLE_STEP_EN: three step pulses on the first program → after each, state=IDLE with pc=1,2,3 and acc=05,08,08. Without the macro: no state change.
